// File: rtl/loader_pkg.sv
// Shared types for the serial instruction-memory loader: FSM states, frame
// constants and the reset value of the status outputs.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic cpu_hold;
    logic busy;
    logic done;
    logic error;
  } status_t;

  localparam status_t STATUS_RST  = '{cpu_hold: 1'b0, busy: 1'b0, done: 1'b0, error: 1'b0};
  localparam status_t STATUS_LOAD = '{cpu_hold: 1'b1, busy: 1'b1, done: 1'b0, error: 1'b0};
  localparam status_t STATUS_OK   = '{cpu_hold: 1'b0, busy: 1'b0, done: 1'b1, error: 1'b0};
  localparam status_t STATUS_FAIL = '{cpu_hold: 1'b1, busy: 1'b0, done: 1'b0, error: 1'b1};

endpackage

// File: rtl/word_packer.sv
// Packs payload bytes MSB-first into 32-bit words; word_vld is combinational on
// the 4th byte so the caller can register the write. No backpressure.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  assign word_vld = byte_vld && (cnt == 2'(WORD_BYTES - 1));
  assign word_dat = {sr, byte_dat};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      sr  <= '0;
    end else if (byte_vld) begin
      cnt <= cnt + 2'd1;
      sr  <= {sr[15:0], byte_dat};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed UART image into instruction RAM, CPU held in reset meanwhile.
// Registered outputs, one byte per rx_valid, no backpressure; IMEM_LOADER_CHECKSUM_EN adds a trailing sum byte.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] WCNT_ONE = 1;

  state_t          state;
  status_t         st;
  logic [7:0]      len_hi;
  logic [ADDR_W:0] nwords;
  logic [ADDR_W:0] wcnt;
  logic [15:0]     len_n;
  logic            len_bad;
  logic            pk_vld;
  logic            word_vld;
  logic [31:0]     word_dat;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign len_n   = {len_hi, rx_data};
  assign len_bad = (len_n == 16'd0) || (32'(len_n) > 32'(DEPTH));
  // Once the last word is out, stray bytes must not start a new partial word.
  assign pk_vld  = rx_valid && !start && (state == S_DATA) && (wcnt != nwords);

  assign cpu_hold = st.cpu_hold;
  assign busy     = st.busy;
  assign done     = st.done;
  assign error    = st.error;

  word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .byte_vld (pk_vld),
    .byte_dat (rx_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      st         <= STATUS_RST;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_hi     <= '0;
      nwords     <= '0;
      wcnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        state <= S_LEN_HI;
        st    <= STATUS_LOAD;
        wcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum  <= '0;
`endif
      end else begin
        case (state)
          S_LEN_HI: if (rx_valid) begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: if (rx_valid) begin
            if (len_bad) begin
              state <= S_ERR;
              st    <= STATUS_FAIL;
            end else begin
              nwords <= len_n[ADDR_W:0];
              state  <= S_DATA;
            end
          end
          S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (pk_vld) csum <= csum + rx_data;
`endif
            if (word_vld) begin
              imem_we    <= 1'b1;
              imem_addr  <= wcnt[ADDR_W-1:0];
              imem_wdata <= word_dat;
              wcnt       <= wcnt + WCNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
              if (wcnt + WCNT_ONE == nwords) state <= S_CSUM;
`endif
            end
`ifndef IMEM_LOADER_CHECKSUM_EN
            else if (wcnt == nwords) begin
              state <= S_DONE;
              st    <= STATUS_OK;
            end
`endif
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CSUM: if (rx_valid) begin
            state <= (rx_data == csum) ? S_DONE : S_ERR;
            st    <= (rx_data == csum) ? STATUS_OK : STATUS_FAIL;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of frame vectors plus hand-written abort/reset sequences.
module tb_imem_loader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, busy, done, error;

  int checks = 0;
  int errors = 0;

  logic [31:0]   prog [DEPTH];
  logic [AW-1:0] wq_addr [$];
  logic [31:0]   wq_data [$];
  logic [7:0]    acc;

  typedef struct {
    logic [15:0] len;
    int          nbytes;
    logic        bad_csum;
    logic        exp_done;
    logic        exp_error;
    logic        exp_hold;
    int          exp_writes;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int i);
    logic [31:0] w;
    w = prog[i / 4];
    case (i % 4)
      0: return w[31:24];
      1: return w[23:16];
      2: return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    acc = 8'h00;
  endtask

  task automatic send_payload(input int first, input int n);
    logic [7:0] b;
    for (int i = first; i < first + n; i++) begin
      b = get_byte(i);
      acc = acc + b;
      send_byte(b);
    end
  endtask

  // Closes a valid-length frame: checksum byte, or one idle cycle for DONE latency.
  task automatic send_tail(input string nm, input logic bad);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad ? acc + 8'd1 : acc);
`else
    chk({nm, ".we_last"}, 32'(imem_we), 32'd1);
    chk({nm, ".done_early"}, 32'(done), 32'd0);
    if (bad) chk({nm, ".unused"}, 32'(error), 32'd0);
    @(negedge clk);
`endif
  endtask

  task automatic check_outputs_reset(input string nm);
    chk({nm, ".we"}, 32'(imem_we), 32'd0);
    chk({nm, ".addr"}, 32'(imem_addr), 32'd0);
    chk({nm, ".wdata"}, imem_wdata, 32'd0);
    chk({nm, ".hold"}, 32'(cpu_hold), 32'd0);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".done"}, 32'(done), 32'd0);
    chk({nm, ".error"}, 32'(error), 32'd0);
  endtask

  task automatic check_writes(input string nm, input int n);
    chk({nm, ".nwrites"}, 32'(wq_addr.size()), 32'(n));
    for (int k = 0; k < wq_addr.size() && k < n; k++) begin
      chk($sformatf("%s.addr%0d", nm, k), 32'(wq_addr[k]), 32'(k));
      chk($sformatf("%s.data%0d", nm, k), wq_data[k], prog[k]);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    pulse_start();
    chk({nm, ".busy_start"}, 32'(busy), 32'd1);
    chk({nm, ".hold_start"}, 32'(cpu_hold), 32'd1);
    send_byte(v.len[15:8]);
    send_byte(v.len[7:0]);
    send_payload(0, v.nbytes);
    if (v.exp_writes > 0) send_tail(nm, v.bad_csum);
    #1;
    chk({nm, ".done"}, 32'(done), 32'(v.exp_done));
    chk({nm, ".error"}, 32'(error), 32'(v.exp_error));
    chk({nm, ".hold"}, 32'(cpu_hold), 32'(v.exp_hold));
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    check_writes(nm, v.exp_writes);
  endtask

  initial begin
    int nw;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; acc = 8'h00;
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'hC0DE0000 ^ (32'(i) * 32'h01030507);
    prog[0] = 32'h3C104000;
    prog[1] = 32'h20140001;
    prog[2] = 32'h08000003;

    vecs[0] = '{16'd3,    12, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[1] = '{16'd0,     0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[2] = '{16'd17,    0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[3] = '{16'd16,   64, 1'b0, 1'b1, 1'b0, 1'b0, 16};
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs[4] = '{16'd1,     4, 1'b1, 1'b0, 1'b1, 1'b1, 1};
`else
    vecs[4] = '{16'd1,     4, 1'b0, 1'b1, 1'b0, 1'b0, 1};
`endif
    vecs[5] = '{16'h0110,  0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[6] = '{16'd2,     8, 1'b0, 1'b1, 1'b0, 1'b0, 2};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_outputs_reset("rst");

    // rx bytes in IDLE are ignored
    send_payload(0, 4);
    #1;
    chk("idle_rx.nwrites", 32'(wq_addr.size()), 32'd0);
    chk("idle_rx.busy", 32'(busy), 32'd0);

    for (int t = 0; t < 7; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

    // abort after 6 payload bytes, then a fresh one-word frame
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_payload(0, 6);
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_payload(0, 4);
    send_tail("abort", 1'b0);
    #1;
    chk("abort.done", 32'(done), 32'd1);
    check_writes("abort", 1);

    // start coincident with rx_valid mid-DATA: byte must be dropped
    prog[0] = 32'hDEADBEEF;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_payload(0, 2);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    wq_addr.delete(); wq_data.delete(); acc = 8'h00;
    send_byte(8'h00); send_byte(8'h01);
    send_payload(0, 4);
    send_tail("coinc", 1'b0);
    #1;
    chk("coinc.done", 32'(done), 32'd1);
    chk("coinc.error", 32'(error), 32'd0);
    check_writes("coinc", 1);

    // rx bytes while DONE are ignored
    nw = wq_addr.size();
    send_payload(0, 8);
    #1;
    chk("done_rx.nwrites", 32'(wq_addr.size()), 32'(nw));
    chk("done_rx.done", 32'(done), 32'd1);
    chk("done_rx.hold", 32'(cpu_hold), 32'd0);

    // reset mid-DATA after one word has been written
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_payload(0, 5);
    chk("midrst.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs_reset("midrst");
    wq_addr.delete(); wq_data.delete();
    send_payload(0, 4);
    #1;
    chk("midrst.idle_nwrites", 32'(wq_addr.size()), 32'd0);
    chk("midrst.idle_busy", 32'(busy), 32'd0);
    chk("midrst.idle_hold", 32'(cpu_hold), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
